// File: rtl/uart_packet_decoder.sv
// uart_packet_decoder: assembles UART bytes into 24-bit pixel packets, validates them and writes pixels to image RAM.
// Latency: ram_we is high for the one cycle after the clock edge that samples a packet's third byte.
// Backpressure: none; every rx_valid strobe is consumed, and a stalled partial packet is dropped after an inter-byte timeout.
module uart_packet_decoder #(
  parameter int         FREQ         = 50_000_000,
  parameter int         BAUD         = 312_500,
  parameter int         NUM_PIXELS   = 785,
  parameter logic [2:0] HEADER       = 3'b101,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        ram_we,
  output logic [9:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic [31:0] count_packets,
  output logic [15:0] hdr_err,
  output logic [15:0] ftr_err,
  output logic [15:0] tmo_err,
  output logic        receive_done
);

  // Computed in 64 bits so large FREQ/TIMEOUT_BITS products cannot overflow.
  localparam longint      TMO_CYCLES = longint'(TIMEOUT_BITS) * longint'(FREQ) / longint'(BAUD);
  localparam int          TW         = $clog2(TMO_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
  localparam logic [10:0] NPIX_LOC   = 11'(NUM_PIXELS);
  localparam logic [31:0] NPIX_CNT   = 32'(NUM_PIXELS);

  typedef enum logic [2:0] {IDLE, GOT1, GOT2, CHECK, DONE} state_t;

  state_t                state, state_nxt;
  logic [4:0]            byte0_lo;   // header bits are already validated, only the loc bits are kept
  logic [7:0]            byte1;
  logic [TW-1:0]         tmo_cnt;
  logic [NUM_PIXELS-1:0] seen;

  logic [9:0] pkt_loc;
  logic [7:0] pkt_data;
  logic [2:0] pkt_ftr, exp_ftr;
  logic       pkt_ok, hdr_ok, tmo_hit, seen_hit;
  logic       take0, take1, load_wr, hdr_inc, ftr_inc, tmo_inc, new_loc;

  // Packet fields as they would be if rx_byte were the third byte.
  assign pkt_loc  = {byte0_lo, byte1[7:3]};
  assign pkt_data = {byte1[2:0], rx_byte[7:3]};
  assign pkt_ftr  = rx_byte[2:0];
  assign exp_ftr  = {^pkt_data, ^pkt_loc, ^{pkt_data[7:4], pkt_loc[9:5]}};
  assign pkt_ok   = (pkt_ftr == exp_ftr) && ({1'b0, pkt_loc} < NPIX_LOC);
  assign hdr_ok   = (rx_byte[7:5] == HEADER);
  assign tmo_hit  = !rx_valid && (tmo_cnt == TMO_LAST);

  // Bitmap lookup for the location being written in the CHECK cycle.
  always_comb begin
    seen_hit = 1'b0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (ram_addr == 10'(i)) seen_hit = seen[i];
    end
  end

  // Next state and one-cycle control strobes.
  always_comb begin
    state_nxt = state;
    take0     = 1'b0;
    take1     = 1'b0;
    load_wr   = 1'b0;
    hdr_inc   = 1'b0;
    ftr_inc   = 1'b0;
    tmo_inc   = 1'b0;
    new_loc   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (hdr_ok) begin
            take0     = 1'b1;
            state_nxt = GOT1;
          end else begin
            hdr_inc = 1'b1;
          end
        end
      end
      GOT1: begin
        if (rx_valid) begin
          take1     = 1'b1;
          state_nxt = GOT2;
        end else if (tmo_hit) begin
          tmo_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GOT2: begin
        if (rx_valid) begin
          load_wr   = pkt_ok;
          state_nxt = CHECK;
        end else if (tmo_hit) begin
          tmo_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        // ram_we was registered from the footer/range result of the third byte.
        if (ram_we) new_loc = !seen_hit;
        else        ftr_inc = 1'b1;
        if (new_loc && (count_packets + 32'd1 == NPIX_CNT)) begin
          state_nxt = DONE;
        end else begin
          state_nxt = IDLE;
          // A byte landing in CHECK is treated exactly as in IDLE.
          if (rx_valid) begin
            if (hdr_ok) begin
              take0     = 1'b1;
              state_nxt = GOT1;
            end else begin
              hdr_inc = 1'b1;
            end
          end
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; clear restarts for a new image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  // Byte capture and inter-byte gap counter (runs only mid-packet).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte0_lo <= '0;
      byte1    <= '0;
      tmo_cnt  <= '0;
    end else if (clear) begin
      byte0_lo <= '0;
      byte1    <= '0;
      tmo_cnt  <= '0;
    end else begin
      if (take0) byte0_lo <= rx_byte[4:0];
      if (take1) byte1    <= rx_byte;
      if (rx_valid || tmo_hit || !(state == GOT1 || state == GOT2)) tmo_cnt <= '0;
      else                                                          tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // RAM write port; address and data hold their last accepted values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (clear) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= load_wr;
      if (load_wr) begin
        ram_addr  <= pkt_loc;
        ram_wdata <= pkt_data;
      end
    end
  end

  // Location bitmap, unique-packet count and sticky completion flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seen          <= '0;
      count_packets <= '0;
      receive_done  <= 1'b0;
    end else if (clear) begin
      seen          <= '0;
      count_packets <= '0;
      receive_done  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        if (new_loc && ram_addr == 10'(i)) seen[i] <= 1'b1;
      end
      if (new_loc) count_packets <= count_packets + 32'd1;
      if (state_nxt == DONE) receive_done <= 1'b1;
    end
  end

  // Saturating error counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_err <= '0;
      ftr_err <= '0;
      tmo_err <= '0;
    end else if (clear) begin
      hdr_err <= '0;
      ftr_err <= '0;
      tmo_err <= '0;
    end else begin
      if (hdr_inc && hdr_err != 16'hFFFF) hdr_err <= hdr_err + 16'd1;
      if (ftr_inc && ftr_err != 16'hFFFF) ftr_err <= ftr_err + 16'd1;
      if (tmo_inc && tmo_err != 16'hFFFF) tmo_err <= tmo_err + 16'd1;
    end
  end

endmodule
